// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit with HI/LO registers.
//
// Runs mult/multu/div/divu over a fixed busy window and mthi/mtlo in a single
// cycle. The 64-bit result is computed combinationally when the operation is
// accepted and parked in a pending register. HI/LO are written from that
// register on the last busy cycle, so the latency seen by the pipeline stays
// fixed no matter how the arithmetic is implemented.
//
// Ports
//   Clk    in   1   clock, rising edge
//   Reset  in   1   synchronous, active-high
//   A      in   32  forwarded rs value
//   B      in   32  forwarded rt value
//   MDUop  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   Req    in   1   E-stage instruction valid
//   Start  out  1   an op is accepted this cycle (combinational)
//   Busy   out  1   a multiply/divide is in flight
//   HI     out  32  HI register
//   LO     out  32  LO register
//   Out    out  32  HI for mfhi, LO for mflo, else 0
//
// States
//   state | meaning
//   IDLE  | no op in flight; accepts new ops and mthi/mtlo
//   RUN   | counting down the busy window; ignores all ops
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUop,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [63:0]        pending, pendingNext;
    logic [31:0]        hiNext, loNext;
    logic [63:0]        result;

    // ------------------------------------------------------------------
    // Arithmetic. Signed divide works on magnitudes so that
    // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    // ------------------------------------------------------------------
    logic [63:0] prodS, prodU;
    logic [31:0] magA, magB, divisor, qMag, rMag, qS, rS, qU, rU;

    always_comb begin
        prodS   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prodU   = {32'd0, A} * {32'd0, B};
        magA    = A[31] ? (~A + 32'd1) : A;
        magB    = B[31] ? (~B + 32'd1) : B;
        // Divisor of zero is replaced to keep the dividers well defined;
        // the result is discarded in that case anyway.
        divisor = (MDUop == OP_DIV) ? magB : B;
        if (divisor == 32'd0) begin
            divisor = 32'd1;
        end
        qMag    = magA / divisor;
        rMag    = magA % divisor;
        qS      = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
        rS      = A[31] ? (~rMag + 32'd1) : rMag;
        qU      = A / divisor;
        rU      = A % divisor;

        case (MDUop)
            OP_MULT:  result = prodS;
            OP_MULTU: result = prodU;
            OP_DIV:   result = (B == 32'd0) ? {HI, LO} : {rS, qS};
            OP_DIVU:  result = (B == 32'd0) ? {HI, LO} : {rU, qU};
            default:  result = {HI, LO};
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            pending <= pendingNext;
            HI      <= hiNext;
            LO      <= loNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        pendingNext = pending;
        hiNext      = HI;
        loNext      = LO;
        case (state)
            IDLE: begin
                if (Start) begin
                    stateNext   = RUN;
                    pendingNext = result;
                    cntNext     = (MDUop == OP_MULT || MDUop == OP_MULTU)
                                  ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end else if (Req && MDUop == OP_MTHI) begin
                    hiNext = A;
                end else if (Req && MDUop == OP_MTLO) begin
                    loNext = A;
                end
            end
            RUN: begin
                cntNext = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    stateNext = IDLE;
                    hiNext    = pending[63:32];
                    loNext    = pending[31:0];
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        Start = Req && (state == IDLE) &&
                (MDUop == OP_MULT || MDUop == OP_MULTU ||
                 MDUop == OP_DIV  || MDUop == OP_DIVU);
        Busy  = (state == RUN);
        case (MDUop)
            OP_MFHI: Out = HI;
            OP_MFLO: Out = LO;
            default: Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] A, B;
    logic [3:0]  MDUop;
    logic        Req;
    logic        Start, Busy;
    logic [31:0] HI, LO, Out;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] expHi, expLo;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .MDUop (MDUop),
        .Req   (Req),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .Out   (Out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idleInputs();
        Req   = 1'b0;
        MDUop = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    // Drive an op in the current cycle (called just after a falling edge).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string nm);
        Req   = 1'b1;
        MDUop = op;
        A     = a;
        B     = b;
        #1;
        check({nm, "_start"}, 32'(Start), 32'd1);
    endtask

    // Cycles 1..n must be busy with HI/LO unchanged; cycle n+1 idle again.
    task automatic runBusy(input int n, input string nm);
        for (int k = 1; k <= n; k++) begin
            @(negedge Clk);
            if (k == 1) idleInputs();
            #1;
            check($sformatf("%s_busy%0d", nm, k), 32'(Busy), 32'd1);
            if (k == n) begin
                check({nm, "_oldhi"}, HI, expHi);
                check({nm, "_oldlo"}, LO, expLo);
            end
        end
        @(negedge Clk);
        idleInputs();
        #1;
        check({nm, "_busydone"}, 32'(Busy), 32'd0);
    endtask

    task automatic checkHiLo(input string nm);
        check({nm, "_hi"}, HI, expHi);
        check({nm, "_lo"}, LO, expLo);
        Req   = 1'b1;
        MDUop = 4'd7;
        #1;
        check({nm, "_mfhi"}, Out, expHi);
        MDUop = 4'd8;
        #1;
        check({nm, "_mflo"}, Out, expLo);
        idleInputs();
    endtask

    initial begin
        vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, MULT_N};
        vecs[1] = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DIV_N};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
        vecs[3] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
        vecs[5] = '{4'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, MULT_N};
        vecs[6] = '{4'd2, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, MULT_N};
        vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
        vecs[8] = '{4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, DIV_N};
        vecs[9] = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, DIV_N};

        idleInputs();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        expHi = 32'd0;
        expLo = 32'd0;
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_start", 32'(Start), 32'd0);
        check("rst_out", Out, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);

        // Req=0 with a multiply opcode must not start anything.
        @(negedge Clk);
        MDUop = 4'd1; A = 32'd3; B = 32'd5;
        #1;
        check("noreq_start", 32'(Start), 32'd0);
        @(negedge Clk);
        #1;
        check("noreq_busy", 32'(Busy), 32'd0);
        idleInputs();
        @(negedge Clk);
        #1;
        check("noreq_busy2", 32'(Busy), 32'd0);
        check("noreq_lo", LO, 32'd0);

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            runBusy(vecs[i].n, $sformatf("vec%0d", i));
            expHi = vecs[i].hi;
            expLo = vecs[i].lo;
            checkHiLo($sformatf("vec%0d", i));
        end

        // mthi then mfhi the next cycle; no busy window.
        @(negedge Clk);
        Req = 1'b1; MDUop = 4'd5; A = 32'h12345678;
        #1;
        check("mthi_start", 32'(Start), 32'd0);
        @(negedge Clk);
        MDUop = 4'd7; A = 32'd0;
        #1;
        check("mthi_busy", 32'(Busy), 32'd0);
        check("mthi_mfhi", Out, 32'h12345678);
        expHi = 32'h12345678;
        idleInputs();

        // Divide by zero: full busy window, HI/LO untouched.
        @(negedge Clk);
        issue(4'd3, 32'd5, 32'd0, "divz");
        runBusy(DIV_N, "divz");
        checkHiLo("divz");

        // mtlo during a multiply is ignored; product lands on schedule.
        @(negedge Clk);
        issue(4'd1, 32'd3, 32'd5, "mtlorun");
        for (int k = 1; k <= MULT_N; k++) begin
            @(negedge Clk);
            idleInputs();
            if (k == 2) begin
                Req = 1'b1; MDUop = 4'd6; A = 32'd9;
                #1;
                check("mtlorun_start", 32'(Start), 32'd0);
            end
            #1;
            check($sformatf("mtlorun_busy%0d", k), 32'(Busy), 32'd1);
            if (k == 3) check("mtlorun_lomid", LO, expLo);
        end
        @(negedge Clk);
        idleInputs();
        #1;
        check("mtlorun_done", 32'(Busy), 32'd0);
        expHi = 32'd0;
        expLo = 32'd15;
        checkHiLo("mtlorun");

        // Reset in cycle 3 of a divide aborts it with no late write.
        @(negedge Clk);
        issue(4'd4, 32'd7, 32'd2, "rstrun");
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            idleInputs();
            #1;
            check($sformatf("rstrun_busy%0d", k), 32'(Busy), 32'd1);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        expHi = 32'd0;
        expLo = 32'd0;
        check("rstrun_busy", 32'(Busy), 32'd0);
        check("rstrun_hi", HI, 32'd0);
        check("rstrun_lo", LO, 32'd0);
        repeat (DIV_N + 2) @(negedge Clk);
        #1;
        check("rstrun_late_busy", 32'(Busy), 32'd0);
        check("rstrun_late_hi", HI, 32'd0);
        check("rstrun_late_lo", LO, 32'd0);

        // Back-to-back: multu issued in the first cycle after a div completes.
        @(negedge Clk);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, "b2b_div");
        runBusy(DIV_N, "b2b_div");
        expHi = 32'd0;
        expLo = 32'h80000000;
        check("b2b_div_hi", HI, expHi);
        check("b2b_div_lo", LO, expLo);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_mul");
        runBusy(MULT_N, "b2b_mul");
        expHi = 32'hFFFFFFFE;
        expLo = 32'h00000001;
        checkHiLo("b2b_mul");

        repeat (2) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
